hazard_ctrl: RTL and testbench

Pipeline interlock and multdiv scheduler for the 5-stage CPU. Sits beside the bypass unit in the decode/execute boundary. It generates every stall, flush and bubble signal the pipeline latches consume, and sequences the multicycle multdiv unit: it starts it, holds the pipeline while it runs, and hands its result back. Where the bypass unit cannot cover a hazard (load-use, multicycle ops, taken branches), this block resolves it.

---
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline interlock and multdiv scheduler for the 5-stage CPU
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      ctrl_dx,
    input  logic             dx_is_mult,
    input  logic             dx_is_div,
    input  logic [4:0]       fd_rs,
    input  logic [4:0]       fd_rt,
    input  logic             fd_uses_rt,
    input  logic             branch_taken,
    input  logic             md_ready,
    output logic             md_ctrl_mult,
    output logic             md_ctrl_div,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             stall_dx,
    output logic             bubble_dx,
    output logic             bubble_xm,
    output logic             flush_fd,
    output logic             md_result_sel,
    output logic             md_exception,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WD_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] wd_next;
    logic            timeout_flag;
    logic [4:0]      dx_rd;
    logic            load_use;
    logic            md_req;
    logic            unused_ctrl;

    assign dx_rd       = ctrl_dx[31:27];
    assign md_req      = dx_is_mult | dx_is_div;
    assign wd_next     = watchdog + 1'b1;
    assign unused_ctrl = ^{ctrl_dx[26:16], ctrl_dx[14], ctrl_dx[12:0]};

    // A load into r0 never creates a dependency, so it needs no bubble.
    assign load_use = ctrl_dx[13] & ctrl_dx[15] & (dx_rd != 5'd0) &
                      ((dx_rd == fd_rs) | (fd_uses_rt & (dx_rd == fd_rt)));

    always_comb begin
        md_ctrl_mult  = 1'b0;
        md_ctrl_div   = 1'b0;
        stall_pc      = 1'b0;
        stall_fd      = 1'b0;
        stall_dx      = 1'b0;
        bubble_dx     = 1'b0;
        bubble_xm     = 1'b0;
        flush_fd      = 1'b0;
        md_result_sel = 1'b0;
        md_exception  = 1'b0;
        case (state)
            IDLE: begin
                if (branch_taken) begin
                    flush_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end else if (md_req) begin
                    md_ctrl_mult = dx_is_mult;
                    md_ctrl_div  = dx_is_div & ~dx_is_mult;
                    stall_pc     = 1'b1;
                    stall_fd     = 1'b1;
                    stall_dx     = 1'b1;
                    bubble_xm    = 1'b1;
                end else if (load_use) begin
                    stall_pc  = 1'b1;
                    stall_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end
            end
            MD_BUSY: begin
                stall_pc  = 1'b1;
                stall_fd  = 1'b1;
                stall_dx  = 1'b1;
                bubble_xm = 1'b1;
            end
            MD_DONE: begin
                md_result_sel = 1'b1;
                md_exception  = timeout_flag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            watchdog     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!branch_taken && md_req) begin
                        state    <= MD_BUSY;
                        watchdog <= '0;
                    end
                end
                MD_BUSY: begin
                    watchdog <= wd_next;
                    // A ready pulse on the last allowed cycle still counts as success.
                    if (md_ready) begin
                        state        <= MD_DONE;
                        timeout_flag <= 1'b0;
                    end else if (wd_next == WD_W'(MD_TIMEOUT - 1)) begin
                        state        <= MD_DONE;
                        timeout_flag <= 1'b1;
                    end
                end
                MD_DONE: begin
                    state        <= IDLE;
                    timeout_flag <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall_pc && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int MD_TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ctrl_dx;
    logic        dx_is_mult, dx_is_div;
    logic [4:0]  fd_rs, fd_rt;
    logic        fd_uses_rt, branch_taken, md_ready;

    logic        a_mult, a_div, a_pc, a_fd, a_dx, a_bdx, a_bxm, a_flush, a_sel, a_exc;
    logic        b_mult, b_div, b_pc, b_fd, b_dx, b_bdx, b_bxm, b_flush, b_sel, b_exc;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    bit m_busy, m_done, m_to;
    int m_cyc, m_start, m_cnt_a, m_cnt_b;

    always #5 clock = ~clock;

    hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset), .ctrl_dx(ctrl_dx),
        .dx_is_mult(dx_is_mult), .dx_is_div(dx_is_div),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
        .branch_taken(branch_taken), .md_ready(md_ready),
        .md_ctrl_mult(a_mult), .md_ctrl_div(a_div),
        .stall_pc(a_pc), .stall_fd(a_fd), .stall_dx(a_dx),
        .bubble_dx(a_bdx), .bubble_xm(a_bxm), .flush_fd(a_flush),
        .md_result_sel(a_sel), .md_exception(a_exc), .stall_count(a_cnt)
    );

    hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(4)) u_sat (
        .clock(clock), .reset(reset), .ctrl_dx(ctrl_dx),
        .dx_is_mult(dx_is_mult), .dx_is_div(dx_is_div),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
        .branch_taken(branch_taken), .md_ready(md_ready),
        .md_ctrl_mult(b_mult), .md_ctrl_div(b_div),
        .stall_pc(b_pc), .stall_fd(b_fd), .stall_dx(b_dx),
        .bubble_dx(b_bdx), .bubble_xm(b_bxm), .flush_fd(b_flush),
        .md_result_sel(b_sel), .md_exception(b_exc), .stall_count(b_cnt)
    );

    function automatic logic [39:0] observed();
        return {a_mult, a_div, a_pc, a_fd, a_dx, a_bdx, a_bxm, a_flush, a_sel, a_exc,
                b_mult, b_div, b_pc, b_fd, b_dx, b_bdx, b_bxm, b_flush, b_sel, b_exc,
                a_cnt, b_cnt};
    endfunction

    // Unused control bits are randomised so the design is shown to ignore them.
    function automatic logic [31:0] mk_ctrl(input logic [4:0] rd, input logic rwe, input logic m2r);
        return {rd, 11'($urandom), rwe, 1'($urandom), m2r, 13'($urandom)};
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        ctrl_dx      = 32'd0;
        dx_is_mult   = 1'b0;
        dx_is_div    = 1'b0;
        fd_rs        = 5'd0;
        fd_rt        = 5'd0;
        fd_uses_rt   = 1'b0;
        branch_taken = 1'b0;
        md_ready     = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        set_idle();
        reset = 1'b0;
        #1;
        check(tag, observed(), 40'd0);
        m_busy  = 0;
        m_done  = 0;
        m_to    = 0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One pipeline cycle: inputs already applied at the falling edge.
    task automatic step(input string tag);
        logic [9:0] e;
        logic [4:0] rd;
        bit         lu;
        #1;
        e  = '0;
        rd = ctrl_dx[31:27];
        lu = ctrl_dx[13] && ctrl_dx[15] && rd != 0 &&
             (rd == fd_rs || (fd_uses_rt && rd == fd_rt));
        if (m_done) begin
            e[1] = 1'b1;
            e[0] = m_to;
        end else if (m_busy) begin
            e[7] = 1'b1; e[6] = 1'b1; e[5] = 1'b1; e[3] = 1'b1;
        end else if (branch_taken) begin
            e[4] = 1'b1; e[2] = 1'b1;
        end else if (dx_is_mult || dx_is_div) begin
            e[9] = dx_is_mult;
            e[8] = !dx_is_mult;
            e[7] = 1'b1; e[6] = 1'b1; e[5] = 1'b1; e[3] = 1'b1;
        end else if (lu) begin
            e[7] = 1'b1; e[6] = 1'b1; e[4] = 1'b1;
        end
        check(tag, observed(), {e, e, 16'(m_cnt_a), 4'(m_cnt_b)});
        if (e[7]) begin
            m_cnt_a = (m_cnt_a == 65535) ? 65535 : m_cnt_a + 1;
            m_cnt_b = (m_cnt_b == 15) ? 15 : m_cnt_b + 1;
        end
        if (m_done) begin
            m_done = 0;
            m_to   = 0;
        end else if (m_busy) begin
            if (md_ready) begin
                m_busy = 0; m_done = 1; m_to = 0;
            end else if (m_cyc - m_start == MD_TIMEOUT - 1) begin
                m_busy = 0; m_done = 1; m_to = 1;
            end
        end else if (!branch_taken && (dx_is_mult || dx_is_div)) begin
            m_busy  = 1;
            m_start = m_cyc;
        end
        @(posedge clock);
        m_cyc++;
        @(negedge clock);
    endtask

    initial begin
        m_cyc = 0;
        reset = 1'b0;
        set_idle();
        @(negedge clock);
        do_reset("reset");

        ctrl_dx = mk_ctrl(5'd5, 1'b1, 1'b1); fd_rs = 5'd5; fd_rt = 5'd9;
        step("loaduse_rs");
        set_idle(); step("loaduse_after");
        ctrl_dx = mk_ctrl(5'd7, 1'b1, 1'b1); fd_rs = 5'd2; fd_rt = 5'd7; fd_uses_rt = 1'b1;
        step("loaduse_rt");
        fd_uses_rt = 1'b0; step("loaduse_rt_unused");
        ctrl_dx = mk_ctrl(5'd0, 1'b1, 1'b1); fd_rs = 5'd0;
        step("loaduse_r0");
        ctrl_dx = mk_ctrl(5'd5, 1'b0, 1'b1); fd_rs = 5'd5;
        step("loaduse_no_rwe");
        set_idle();

        for (int k = 0; k <= 19; k++) begin
            dx_is_mult = (k <= 18);
            md_ready   = (k == 0 || k == 17);
            step($sformatf("mult_c%0d", k));
        end
        set_idle();

        for (int k = 0; k <= 41; k++) begin
            dx_is_div = (k <= 40);
            step($sformatf("timeout_c%0d", k));
        end
        set_idle();

        for (int k = 0; k <= 41; k++) begin
            dx_is_div = (k <= 40);
            md_ready  = (k == MD_TIMEOUT - 1);
            step($sformatf("ready_on_timeout_c%0d", k));
        end
        set_idle();

        branch_taken = 1'b1; dx_is_mult = 1'b1; md_ready = 1'b1;
        step("branch_vs_mult");
        branch_taken = 1'b0; dx_is_mult = 1'b0; md_ready = 1'b0;
        step("branch_after");

        dx_is_mult = 1'b1; dx_is_div = 1'b1;
        step("both_start");
        dx_is_mult = 1'b0; md_ready = 1'b1; step("both_ready");
        md_ready = 1'b0; step("both_done");
        dx_is_div = 1'b1; step("back_to_back_start");
        for (int k = 1; k <= 4; k++) begin
            branch_taken = (k == 2);
            step($sformatf("b2b_busy_c%0d", k));
        end
        do_reset("reset_mid_op");
        dx_is_div = 1'b1; step("fresh_div_start");
        md_ready = 1'b1; step("fresh_div_ready");
        md_ready = 1'b0; step("fresh_div_done");
        set_idle(); step("fresh_div_idle");

        for (int k = 0; k < 400; k++) begin
            ctrl_dx      = mk_ctrl(5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            fd_rs        = 5'($urandom_range(0, 3));
            fd_rt        = 5'($urandom_range(0, 3));
            fd_uses_rt   = 1'($urandom);
            branch_taken = ($urandom_range(0, 7) == 0);
            dx_is_mult   = ($urandom_range(0, 9) == 0);
            dx_is_div    = ($urandom_range(0, 9) == 0);
            md_ready     = ($urandom_range(0, 5) == 0);
            step($sformatf("rand_%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
